coherence_bus_ctrl: RTL and testbench

- Two-core memory bus controller and MSI snoop sequencer.
- Sits between the two cores' icache/dcache memory-side ports and the single shared RAM port.
- Arbitrates instruction fetches, dcache writebacks and coherence transactions.
- Drives snoop address and invalidate requests to the non-requesting dcache, and performs cache-to-cache transfers when the snooped cache holds the block modified.

---
 rtl/coherence_bus_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: two-core shared-RAM arbiter and MSI snoop sequencer (WB, snoop, C2C, MEM, IFETCH).
// Define BUS_PERF_CNT_EN to add the c2c_count / mem_rd_count block-transfer counters.
module coherence_bus_ctrl #(
    parameter int CPUS      = 2,
    parameter int BLK_WORDS = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    input  logic [CPUS-1:0]       cctrans,
    input  logic [CPUS-1:0]       ccwrite,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic                  ram_ready,
`ifdef BUS_PERF_CNT_EN
    output logic [31:0]           c2c_count,
    output logic [31:0]           mem_rd_count,
`endif
    input  logic [31:0]           ramload
);
    localparam int WCW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, MEM, IFETCH} state_t;

    state_t         state, state_n;
    logic           req, req_n, last_grant, last_grant_n;
    logic           upg, upg_n, inv, inv_n;
    logic [WCW-1:0] wcnt, wcnt_n;
    logic           other, last_word;
    logic [CPUS-1:0] cc_req;

    assign other     = ~req;
    assign last_word = (wcnt == WCW'(BLK_WORDS - 1));
    // Upgrades (write hit in S) carry cctrans+ccwrite with no data request.
    assign cc_req    = cctrans & (dREN | dWEN | ccwrite);

    // Tie goes to the core that did not win last time.
    function automatic logic pick(input logic [CPUS-1:0] r, input logic lg);
        if (&r) return ~lg;
        return r[1];
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            req        <= 1'b0;
            last_grant <= 1'b1;
            upg        <= 1'b0;
            inv        <= 1'b0;
            wcnt       <= '0;
        end else begin
            state      <= state_n;
            req        <= req_n;
            last_grant <= last_grant_n;
            upg        <= upg_n;
            inv        <= inv_n;
            wcnt       <= wcnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        req_n        = req;
        last_grant_n = last_grant;
        upg_n        = upg;
        inv_n        = inv;
        wcnt_n       = wcnt;
        case (state)
            IDLE: begin
                wcnt_n = '0;
                if (|dWEN) begin
                    req_n        = pick(dWEN, last_grant);
                    last_grant_n = req_n;
                    state_n      = WB;
                end else if (|cc_req) begin
                    req_n        = pick(cc_req, last_grant);
                    last_grant_n = req_n;
                    upg_n        = ~(dREN[req_n] | dWEN[req_n]);
                    inv_n        = ccwrite[req_n];
                    state_n      = SNOOP;
                end else if (|iREN) begin
                    req_n        = pick(iREN, last_grant);
                    last_grant_n = req_n;
                    state_n      = IFETCH;
                end
            end
            WB:     if (!dWEN[req]) state_n = IDLE;
            SNOOP: begin
                if (cctrans[other]) begin
                    if (upg)                 state_n = IDLE;
                    else if (ccwrite[other]) state_n = C2C;
                    else                     state_n = MEM;
                end
            end
            C2C, MEM: begin
                if (ram_ready) begin
                    wcnt_n = wcnt + WCW'(1);
                    if (last_word) state_n = IDLE;
                end
            end
            IFETCH: if (ram_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            WB: begin
                if (dWEN[req]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[req];
                    ramstore = dstore[req];
                    if (ram_ready) dwait[req] = 1'b0;
                end
            end
            SNOOP, C2C, MEM: begin
                // Snoop signals stay up until the IDLE return.
                ccwait[other]      = 1'b1;
                ccinv[other]       = inv;
                ccsnoopaddr[other] = daddr[req];
                if (state == SNOOP && upg && cctrans[other]) dwait[req] = 1'b0;
                if (state == C2C) begin
                    dload[req] = dstore[other];
                    ramWEN     = 1'b1;
                    ramaddr    = daddr[other];
                    ramstore   = dstore[other];
                    if (ram_ready) begin
                        dwait[req]   = 1'b0;
                        dwait[other] = 1'b0;
                    end
                end
                if (state == MEM) begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[req];
                    if (ram_ready) begin
                        dload[req] = ramload;
                        dwait[req] = 1'b0;
                    end
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[req];
                if (ram_ready) begin
                    iload[req] = ramload;
                    iwait[req] = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef BUS_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c2c_count    <= '0;
            mem_rd_count <= '0;
        end else if (ram_ready && last_word) begin
            if (state == C2C) c2c_count    <= c2c_count + 32'd1;
            if (state == MEM) mem_rd_count <= mem_rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: fetch tie, C2C, MEM with invalidate, WB priority, upgrade, reset abort.
module tb_coherence_bus_ctrl;
    logic             CLK, RST;
    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN, ram_ready;
    logic [31:0]      ramaddr, ramstore, ramload;
`ifdef BUS_PERF_CNT_EN
    logic [31:0]      c2c_count, mem_rd_count;
`endif
    int checks = 0;
    int failures = 0;

    coherence_bus_ctrl dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ram_ready(ram_ready),
`ifdef BUS_PERF_CNT_EN
        .c2c_count(c2c_count), .mem_rd_count(mem_rd_count),
`endif
        .ramload(ramload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        iaddr = '0; daddr = '0; dstore = '0; ram_ready = 1'b0; ramload = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        clear_inputs();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        @(negedge CLK); #1;
        checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL rst_iwait got=%b exp=11", iwait); end
        checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL rst_dwait got=%b exp=11", dwait); end
        checks++; if ({ccwait, ccinv} !== 4'b0) begin failures++; $display("FAIL rst_cc got=%b exp=0000", {ccwait, ccinv}); end
        checks++; if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'b0) begin failures++; $display("FAIL rst_ram got=%b%b %h %h exp=0", ramREN, ramWEN, ramaddr, ramstore); end
        checks++; if ({iload, dload, ccsnoopaddr} !== 192'b0) begin failures++; $display("FAIL rst_data got=%h %h %h exp=0", iload, dload, ccsnoopaddr); end
        RST = 1'b0;
    endtask

    task automatic test_ifetch_tie();
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h1000; iaddr[1] = 32'h2000;
        #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL if_idle_ren got=%b exp=0", ramREN); end
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h1000) begin failures++; $display("FAIL if_core0_first got=%b %h exp=1 00001000", ramREN, ramaddr); end
        checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL if_wait_pending got=%b exp=11", iwait); end
        @(negedge CLK);
        @(negedge CLK); ram_ready = 1'b1; ramload = 32'hAAAA0001; #1;
        checks++; if (iwait !== 2'b10 || iload[0] !== 32'hAAAA0001) begin failures++; $display("FAIL if_core0_done got=%b %h exp=10 aaaa0001", iwait, iload[0]); end
        @(negedge CLK); ram_ready = 1'b0; iREN = 2'b10; #1;
        checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL if_pulse_1cyc got=%b exp=11", iwait); end
        @(negedge CLK); #1;
        checks++; if (ramaddr !== 32'h2000) begin failures++; $display("FAIL if_core1_addr got=%h exp=00002000", ramaddr); end
        @(negedge CLK); ram_ready = 1'b1; ramload = 32'hBBBB0002; #1;
        checks++; if (iwait !== 2'b01 || iload[1] !== 32'hBBBB0002) begin failures++; $display("FAIL if_core1_done got=%b %h exp=01 bbbb0002", iwait, iload[1]); end
        @(negedge CLK); clear_inputs();
    endtask

    task automatic test_c2c();
        do_reset();
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
        @(negedge CLK); #1;
        checks++; if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h100 || ccinv !== 2'b00) begin failures++; $display("FAIL c2c_snoop got=%b %h %b exp=10 00000100 00", ccwait, ccsnoopaddr[1], ccinv); end
        cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'hDEADBEEF;
        @(negedge CLK); cctrans[1] = 1'b0; #1;
        checks++; if (dwait !== 2'b11 || ramWEN !== 1'b1) begin failures++; $display("FAIL c2c_stall got=%b %b exp=11 1", dwait, ramWEN); end
        @(negedge CLK); ram_ready = 1'b1; #1;
        checks++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF || ramREN !== 1'b0) begin failures++; $display("FAIL c2c_w0_ram got=%h %h %b exp=00000100 deadbeef 0", ramaddr, ramstore, ramREN); end
        checks++; if (dload[0] !== 32'hDEADBEEF || dwait !== 2'b00) begin failures++; $display("FAIL c2c_w0_load got=%h %b exp=deadbeef 00", dload[0], dwait); end
        @(negedge CLK); daddr[0] = 32'h104; daddr[1] = 32'h104; dstore[1] = 32'hCAFEF00D; #1;
        checks++; if (ramaddr !== 32'h104 || dload[0] !== 32'hCAFEF00D || dwait !== 2'b00) begin failures++; $display("FAIL c2c_w1 got=%h %h %b exp=00000104 cafef00d 00", ramaddr, dload[0], dwait); end
        @(negedge CLK); clear_inputs(); #1;
        checks++; if (ccwait !== 2'b00 || ramWEN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("FAIL c2c_idle got=%b %b %b exp=00 0 11", ccwait, ramWEN, dwait); end
`ifdef BUS_PERF_CNT_EN
        checks++; if (c2c_count !== 32'd1) begin failures++; $display("FAIL c2c_count got=%0d exp=1", c2c_count); end
`endif
    endtask

    task automatic test_mem_inv();
        do_reset();
        dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
        @(negedge CLK); #1;
        checks++; if (ccinv !== 2'b01 || ccwait !== 2'b01 || ccsnoopaddr[0] !== 32'h200) begin failures++; $display("FAIL mem_snoop got=%b %b %h exp=01 01 00000200", ccinv, ccwait, ccsnoopaddr[0]); end
        cctrans[0] = 1'b1;
        @(negedge CLK); cctrans[0] = 1'b0; ram_ready = 1'b1; ramload = 32'h11111111; #1;
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin failures++; $display("FAIL mem_w0_ram got=%b %b %h exp=1 0 00000200", ramREN, ramWEN, ramaddr); end
        checks++; if (dload[1] !== 32'h11111111 || dwait !== 2'b01 || ccinv !== 2'b01) begin failures++; $display("FAIL mem_w0_load got=%h %b %b exp=11111111 01 01", dload[1], dwait, ccinv); end
        @(negedge CLK); daddr[1] = 32'h204; ramload = 32'h22222222; #1;
        checks++; if (ramaddr !== 32'h204 || dload[1] !== 32'h22222222 || dwait !== 2'b01) begin failures++; $display("FAIL mem_w1 got=%h %h %b exp=00000204 22222222 01", ramaddr, dload[1], dwait); end
        @(negedge CLK); clear_inputs(); #1;
        checks++; if (ccinv !== 2'b00 || ccwait !== 2'b00 || ramREN !== 1'b0) begin failures++; $display("FAIL mem_idle got=%b %b %b exp=00 00 0", ccinv, ccwait, ramREN); end
`ifdef BUS_PERF_CNT_EN
        checks++; if (mem_rd_count !== 32'd1) begin failures++; $display("FAIL mem_rd_count got=%0d exp=1", mem_rd_count); end
`endif
    endtask

    task automatic test_wb_priority();
        do_reset();
        dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'h55;
        iREN[1] = 1'b1; iaddr[1] = 32'h400;
        @(negedge CLK); #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || dwait !== 2'b11) begin failures++; $display("FAIL wb_first got=%b %b %h %b exp=1 0 00000300 11", ramWEN, ramREN, ramaddr, dwait); end
        @(negedge CLK); ram_ready = 1'b1; #1;
        checks++; if (dwait !== 2'b10 || ramstore !== 32'h55 || ramREN !== 1'b0) begin failures++; $display("FAIL wb_w0 got=%b %h %b exp=10 00000055 0", dwait, ramstore, ramREN); end
        @(negedge CLK); daddr[0] = 32'h304; dstore[0] = 32'h66; #1;
        checks++; if (ramaddr !== 32'h304 || ramstore !== 32'h66 || dwait !== 2'b10) begin failures++; $display("FAIL wb_w1 got=%h %h %b exp=00000304 00000066 10", ramaddr, ramstore, dwait); end
        @(negedge CLK); dWEN = 2'b00; ram_ready = 1'b0; #1;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin failures++; $display("FAIL wb_drop got=%b %b exp=0 0", ramWEN, ramREN); end
        @(negedge CLK);
        @(negedge CLK); ram_ready = 1'b1; ramload = 32'h77; #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h400 || iwait !== 2'b01) begin failures++; $display("FAIL wb_then_fetch got=%b %h %b exp=1 00000400 01", ramREN, ramaddr, iwait); end
        @(negedge CLK); clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        dWEN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
        @(negedge CLK); #1;
        checks++; if (ramaddr !== 32'h500) begin failures++; $display("FAIL rr_first got=%h exp=00000500", ramaddr); end
        dWEN[0] = 1'b0;
        @(negedge CLK); dWEN = 2'b11;
        @(negedge CLK); #1;
        checks++; if (ramaddr !== 32'h600 || ramWEN !== 1'b1) begin failures++; $display("FAIL rr_second got=%h %b exp=00000600 1", ramaddr, ramWEN); end
        @(negedge CLK); clear_inputs();
    endtask

    task automatic test_upgrade();
        do_reset();
        cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h700;
        @(negedge CLK); #1;
        checks++; if (ccinv !== 2'b10 || ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("FAIL upg_snoop got=%b %b %b %b exp=10 0 0 11", ccinv, ramREN, ramWEN, dwait); end
        cctrans[1] = 1'b1; #1;
        checks++; if (dwait !== 2'b10) begin failures++; $display("FAIL upg_ack got=%b exp=10", dwait); end
        @(negedge CLK); clear_inputs(); #1;
        checks++; if (dwait !== 2'b11 || ccinv !== 2'b00 || ramREN !== 1'b0) begin failures++; $display("FAIL upg_idle got=%b %b %b exp=11 00 0", dwait, ccinv, ramREN); end
    endtask

    task automatic test_reset_mid_c2c();
        do_reset();
        dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
        @(negedge CLK); cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'h1;
        @(negedge CLK); ram_ready = 1'b1;
        @(negedge CLK); daddr[1] = 32'h104; #1;
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h104) begin failures++; $display("FAIL rmid_in_c2c got=%b %h exp=1 00000104", ramWEN, ramaddr); end
        RST = 1'b1; #1;
        checks++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 2'b11 || ccwait !== 2'b00 || dload !== 64'h0) begin failures++; $display("FAIL rmid_abort got=%b %h %b %b %h exp=0 0 11 00 0", ramWEN, ramaddr, dwait, ccwait, dload); end
        @(negedge CLK); RST = 1'b0; clear_inputs();
        iREN = 2'b11; iaddr[0] = 32'h800; iaddr[1] = 32'h900;
        @(negedge CLK); #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin failures++; $display("FAIL rmid_next_core0 got=%b %h exp=1 00000800", ramREN, ramaddr); end
        @(negedge CLK); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifetch_tie();
        test_c2c();
        test_mem_inv();
        test_wb_priority();
        test_round_robin();
        test_upgrade();
        test_reset_mid_c2c();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
